// File: rtl/arbiter_rr.sv
// arbiter_rr: round-robin arbiter for one shared resource among REQ_SIZE
// requesters. It drives a registered one-hot grant, the matching binary
// select, a valid flag, and an optional force-release pulse.
//
// Build option: define ARB_TIMEOUT_EN to bound every grant to HOLD_MAX+1
// cycles. Without the macro, grants are unbounded and oTMO stays 0.
//
// A grant passes through GRANT -> PARK -> IDLE. The PARK cycle is a
// guaranteed dead cycle for bus turnaround. After each release, priority
// rotates past the last owner.

module arbiter_rr #(
  parameter int SEL_SIZE  = 3,
  parameter int REQ_SIZE  = 2**SEL_SIZE,
  parameter int HOLD_MAX  = 15,
  parameter int HOLD_SIZE = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [REQ_SIZE-1:0] iREQ,
  input  logic                iEND,
  output logic [REQ_SIZE-1:0] oGNT,
  output logic [SEL_SIZE-1:0] oSEL,
  output logic                oVLD,
  output logic                oTMO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PARK  = 2'd2
  } state_t;

  // Reject counter widths that cannot represent HOLD_MAX.
  if ((2**HOLD_SIZE) <= HOLD_MAX) begin : g_bad_hold
    $error("arbiter_rr: HOLD_SIZE too small for HOLD_MAX");
  end

  state_t              state_q;
  logic [REQ_SIZE-1:0] gnt_q;
  logic [SEL_SIZE-1:0] sel_q;
  logic                vld_q;
  logic [SEL_SIZE-1:0] ptr_q;

  logic                pick_found;
  logic [SEL_SIZE-1:0] pick_idx;
  logic [SEL_SIZE-1:0] cand;
  logic                rel_norm;
  logic                rel_any;

  // Find the first active request, starting at ptr_q and wrapping around.
  always_comb begin
    // NOTE: every combinational output gets a default first; this prevents latches.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < REQ_SIZE; i++) begin
      cand = SEL_SIZE'((int'(ptr_q) + i) % REQ_SIZE);
      if (!pick_found && iREQ[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // A normal release happens when the owner signals done or withdraws its request.
  assign rel_norm = iEND | ~iREQ[sel_q];

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_SIZE-1:0] hold_q;
  logic                 tmo_q;
  logic                 tmo_hit;

  assign tmo_hit = (hold_q == HOLD_SIZE'(HOLD_MAX));
  assign rel_any = rel_norm | tmo_hit;
  assign oTMO    = tmo_q;

  // Hold counter: clears when a grant starts and counts each GRANT cycle.
  // oTMO flags the PARK cycle that follows a forced release.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hold_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      if (state_q == IDLE) begin
        hold_q <= '0;
      end else if (state_q == GRANT) begin
        if (rel_any) begin
          // A normal release in the same cycle takes precedence, so no pulse.
          tmo_q <= ~rel_norm;
        end else begin
          hold_q <= hold_q + 1'b1;
        end
      end
    end
  end
`else
  assign rel_any = rel_norm;
  assign oTMO    = 1'b0;
`endif

  // Arbitration FSM with registered grant, select and valid outputs.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    if (iRST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt_q   <= REQ_SIZE'(1) << pick_idx;
            sel_q   <= pick_idx;
            vld_q   <= 1'b1;
            state_q <= GRANT;
          end else begin
            gnt_q <= '0;
            vld_q <= 1'b0;
          end
        end
        GRANT: begin
          if (rel_any) begin
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            // REQ_SIZE is 2**SEL_SIZE, so the natural overflow wraps to 0.
            ptr_q   <= sel_q + 1'b1;
            state_q <= PARK;
          end
        end
        PARK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign oGNT = gnt_q;
  assign oSEL = sel_q;
  assign oVLD = vld_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed testbench for arbiter_rr (default parameters: 8 requesters).
// Expected values are hand-derived from the arbitration rules. If the
// design is built with ARB_TIMEOUT_EN, define the same macro for the
// bench so the timeout scenario expects a forced release.

module tb_arbiter_rr;

  logic       iCLK;
  logic       iRST;
  logic [7:0] iREQ;
  logic       iEND;
  logic [7:0] oGNT;
  logic [2:0] oSEL;
  logic       oVLD;
  logic       oTMO;

  int checks;
  int failures;

  arbiter_rr dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .iREQ (iREQ),
    .iEND (iEND),
    .oGNT (oGNT),
    .oSEL (oSEL),
    .oVLD (oVLD),
    .oTMO (oTMO)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // One reset edge; afterwards the DUT is in IDLE with ptr=0.
  task automatic do_reset();
    iRST = 1'b1;
    iEND = 1'b0;
    step();
    iRST = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    iREQ = 8'hFF;
    iEND = 1'b0;
    step();
    step();
    checks++;
    if ({oGNT, oSEL, oVLD, oTMO} !== 13'd0) begin
      $display("FAIL reset_outputs: gnt=%h sel=%0d vld=%b tmo=%b, want all zero",
               oGNT, oSEL, oVLD, oTMO);
      failures++;
    end
    iRST = 1'b0;
    step();
    checks++;
    if (oGNT !== 8'h01 || oSEL !== 3'd0 || oVLD !== 1'b1) begin
      $display("FAIL reset_first_grant: gnt=%h sel=%0d vld=%b, want 01/0/1",
               oGNT, oSEL, oVLD);
      failures++;
    end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_sel [5];
    exp_sel = '{3'd0, 3'd2, 3'd4, 3'd0, 3'd2};
    do_reset();
    iREQ = 8'h15;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (oSEL !== exp_sel[k] || oGNT !== (8'h01 << exp_sel[k]) || oVLD !== 1'b1) begin
        $display("FAIL rotation_grant%0d: gnt=%h sel=%0d vld=%b, want sel=%0d",
                 k, oGNT, oSEL, oVLD, exp_sel[k]);
        failures++;
      end
      iEND = 1'b1;
      step();
      iEND = 1'b0;
      checks++;
      if (oGNT !== 8'h00 || oVLD !== 1'b0 || oSEL !== exp_sel[k]) begin
        $display("FAIL rotation_park%0d: gnt=%h vld=%b sel=%0d, want 00/0/%0d",
                 k, oGNT, oVLD, oSEL, exp_sel[k]);
        failures++;
      end
      step();
      checks++;
      if (oGNT !== 8'h00 || oVLD !== 1'b0) begin
        $display("FAIL rotation_idle%0d: gnt=%h vld=%b, want 00/0", k, oGNT, oVLD);
        failures++;
      end
    end
    iREQ = 8'h00;
  endtask

  task automatic test_wrap();
    do_reset();
    iREQ = 8'h40;
    step();
    checks++;
    if (oGNT !== 8'h40 || oSEL !== 3'd6) begin
      $display("FAIL wrap_grant6: gnt=%h sel=%0d, want 40/6", oGNT, oSEL);
      failures++;
    end
    // Owner 6 withdraws, so ptr becomes 7.
    iREQ = 8'h81;
    step();
    step();
    step();
    checks++;
    if (oGNT !== 8'h80 || oSEL !== 3'd7) begin
      $display("FAIL wrap_grant7: gnt=%h sel=%0d, want 80/7", oGNT, oSEL);
      failures++;
    end
    iEND = 1'b1;
    step();
    iEND = 1'b0;
    step();
    step();
    checks++;
    if (oGNT !== 8'h01 || oSEL !== 3'd0) begin
      $display("FAIL wrap_grant0: gnt=%h sel=%0d, want 01/0", oGNT, oSEL);
      failures++;
    end
    iEND = 1'b1;
    step();
    iEND = 1'b0;
    step();
    step();
    checks++;
    if (oGNT !== 8'h80 || oSEL !== 3'd7) begin
      $display("FAIL wrap_regrant7: gnt=%h sel=%0d, want 80/7", oGNT, oSEL);
      failures++;
    end
    iREQ = 8'h00;
  endtask

  task automatic test_withdraw();
    do_reset();
    iREQ = 8'h08;
    step();
    // Other requesters arriving during GRANT must not disturb the owner.
    iREQ = 8'h2B;
    step();
    checks++;
    if (oGNT !== 8'h08 || oSEL !== 3'd3 || oVLD !== 1'b1) begin
      $display("FAIL withdraw_hold: gnt=%h sel=%0d vld=%b, want 08/3/1", oGNT, oSEL, oVLD);
      failures++;
    end
    iREQ = 8'h23;
    step();
    checks++;
    if (oGNT !== 8'h00 || oVLD !== 1'b0 || oSEL !== 3'd3) begin
      $display("FAIL withdraw_release: gnt=%h vld=%b sel=%0d, want 00/0/3", oGNT, oVLD, oSEL);
      failures++;
    end
    step();
    checks++;
    if (oGNT !== 8'h00) begin
      $display("FAIL withdraw_idle: gnt=%h, want 00", oGNT);
      failures++;
    end
    step();
    checks++;
    if (oGNT !== 8'h20 || oSEL !== 3'd5) begin
      $display("FAIL withdraw_next: gnt=%h sel=%0d, want 20/5", oGNT, oSEL);
      failures++;
    end
    iREQ = 8'h00;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    iREQ = 8'h20;
    step();
    checks++;
    if (oGNT !== 8'h20 || oSEL !== 3'd5) begin
      $display("FAIL midrst_grant: gnt=%h sel=%0d, want 20/5", oGNT, oSEL);
      failures++;
    end
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    checks++;
    if ({oGNT, oSEL, oVLD, oTMO} !== 13'd0) begin
      $display("FAIL midrst_zero: gnt=%h sel=%0d vld=%b tmo=%b, want all zero",
               oGNT, oSEL, oVLD, oTMO);
      failures++;
    end
    step();
    checks++;
    if (oGNT !== 8'h20 || oSEL !== 3'd5 || oVLD !== 1'b1) begin
      $display("FAIL midrst_regrant: gnt=%h sel=%0d vld=%b, want 20/5/1", oGNT, oSEL, oVLD);
      failures++;
    end
    iREQ = 8'h00;
  endtask

  task automatic test_end_in_idle();
    do_reset();
    iREQ = 8'h00;
    iEND = 1'b1;
    step();
    step();
    iEND = 1'b0;
    checks++;
    if (oGNT !== 8'h00 || oVLD !== 1'b0) begin
      $display("FAIL end_idle: gnt=%h vld=%b, want 00/0", oGNT, oVLD);
      failures++;
    end
    // When iEND and a new request arrive together, the release completes first.
    iREQ = 8'h02;
    step();
    iEND = 1'b1;
    iREQ = 8'h06;
    step();
    iEND = 1'b0;
    checks++;
    if (oGNT !== 8'h00 || oSEL !== 3'd1) begin
      $display("FAIL end_newreq_park: gnt=%h sel=%0d, want 00/1", oGNT, oSEL);
      failures++;
    end
    step();
    step();
    checks++;
    if (oGNT !== 8'h04 || oSEL !== 3'd2) begin
      $display("FAIL end_newreq_grant: gnt=%h sel=%0d, want 04/2", oGNT, oSEL);
      failures++;
    end
    iREQ = 8'h00;
  endtask

  task automatic test_timeout();
    do_reset();
    iREQ = 8'h02;
    step();
    checks++;
    if (oGNT !== 8'h02 || oSEL !== 3'd1 || oTMO !== 1'b0) begin
      $display("FAIL tmo_start: gnt=%h sel=%0d tmo=%b, want 02/1/0", oGNT, oSEL, oTMO);
      failures++;
    end
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < 16; c++) begin
      step();
      checks++;
      if (oGNT !== 8'h02 || oTMO !== 1'b0) begin
        $display("FAIL tmo_hold_c%0d: gnt=%h tmo=%b, want 02/0", c, oGNT, oTMO);
        failures++;
      end
    end
    step();
    checks++;
    if (oGNT !== 8'h00 || oVLD !== 1'b0 || oTMO !== 1'b1) begin
      $display("FAIL tmo_pulse: gnt=%h vld=%b tmo=%b, want 00/0/1", oGNT, oVLD, oTMO);
      failures++;
    end
    step();
    checks++;
    if (oTMO !== 1'b0 || oGNT !== 8'h00) begin
      $display("FAIL tmo_pulse_end: tmo=%b gnt=%h, want 0/00", oTMO, oGNT);
      failures++;
    end
    step();
    checks++;
    if (oGNT !== 8'h02 || oTMO !== 1'b0) begin
      $display("FAIL tmo_regrant: gnt=%h tmo=%b, want 02/0", oGNT, oTMO);
      failures++;
    end
`else
    for (int c = 1; c < 120; c++) begin
      step();
      checks++;
      if (oGNT !== 8'h02 || oVLD !== 1'b1 || oTMO !== 1'b0) begin
        $display("FAIL notmo_hold_c%0d: gnt=%h vld=%b tmo=%b, want 02/1/0",
                 c, oGNT, oVLD, oTMO);
        failures++;
      end
    end
`endif
    iREQ = 8'h00;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    iRST     = 1'b1;
    iREQ     = 8'h00;
    iEND     = 1'b0;
    #2;
    test_reset();
    test_rotation();
    test_wrap();
    test_withdraw();
    test_reset_mid_grant();
    test_end_in_idle();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
